data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Word-addressed data memory; the responding end of the load/store port driven by alu_mem.
//  Accepts one LOAD/STORE request at a time over a valid/ready handshake.
//  Waits a programmable access latency, then returns read data or a write acknowledge
//  over a valid/ready response channel. Flags misaligned and out-of-range accesses.
// PARAMETERS
//  DATA_WIDTH  32    width of address, write data and read data
//  DEPTH       1024  number of DATA_WIDTH-bit words; power of 2, >= 2
//  LATENCY     2     access latency in cycles; legal range 1..15
// PORTS
//  clk_i        in   1           clock; all logic on rising edge
//  rst_ni       in   1           synchronous active-low reset
//  req_valid_i  in   1           request present
//  req_ready_o  out  1           responder can accept a request
//  we_i         in   1           1 = STORE, 0 = LOAD
//  addr_i       in   DATA_WIDTH  byte address; must be word aligned
//  wdata_i      in   DATA_WIDTH  store data
//  rsp_valid_o  out  1           response present
//  rsp_ready_i  in   1           requester takes the response
//  rdata_o      out  DATA_WIDTH  load data; 0 for stores and errored accesses
//  err_o        out  1           access was misaligned or out of range; valid with rsp_valid_o
// BEHAVIOUR
//  - Reset (rst_ni=0 at a clock edge):
//    - FSM goes to IDLE; req_ready_o=0 during reset.
//    - rsp_valid_o=0, rdata_o=0, err_o=0; latency counter cleared.
//    - Memory array contents are NOT affected by reset.
//    - Reset overrides any request or response in progress, in any state.
//    - An in-flight STORE whose write has not yet happened is dropped.
//  - FSM states: IDLE, BUSY, RESP.
//  - IDLE: req_ready_o=1.
//    - On req_valid_i&&req_ready_o, capture we_i, addr_i and wdata_i into registers.
//    - Load the counter with LATENCY-1.
//    - Next state is BUSY if LATENCY>1, else RESP.
//  - BUSY: req_ready_o=0. The counter decrements each cycle. When it equals 1, next state is RESP.
//  - Access: occurs on the edge that enters RESP.
//    - STORE: mem[idx] <= wdata; rdata_o <= 0.
//    - LOAD: rdata_o <= mem[idx].
//    - idx = addr[2 +: log2(DEPTH)].
//  - Error: err = (addr[1:0]!=0) || (addr >= DEPTH*4).
//    - On error: no memory write, rdata_o <= 0, err_o <= 1.
//    - Otherwise err_o <= 0.
//  - Timing: with the request accepted at edge N, rsp_valid_o is 1 after edge N+LATENCY-1.
//    - LATENCY=1: rsp_valid_o is high in the cycle after acceptance.
//  - RESP: rsp_valid_o=1, req_ready_o=0.
//    - rdata_o and err_o are held stable until the handshake.
//    - On rsp_ready_i, clear rsp_valid_o and go to IDLE.
//    - A new request can be accepted no earlier than the following cycle.
//  - Backpressure: while rsp_ready_i=0, RESP is held indefinitely. No request is accepted.
//  - Inputs are ignored outside the IDLE accept edge.
//    - addr_i and wdata_i may change during BUSY/RESP without effect.
//  - Throughput: at most one request per LATENCY+1 cycles when rsp_ready_i is held 1.
//  - Read-after-write: a LOAD accepted after a STORE's response handshake returns the stored value.
// TESTING
//  1. Reset, LATENCY=2.
//     - STORE addr=0x10 data=0xDEADBEEF, then LOAD addr=0x10.
//     - Required: rdata_o=0xDEADBEEF, err_o=0.
//     - Required: rsp_valid_o rises 1 cycle after each accept edge.
//  2. LATENCY=1 and LATENCY=15, back-to-back LOADs with rsp_ready_i=1.
//     - Required: response timing exactly per the rule above.
//     - Required: req_ready_o low from accept until the handshake.
//  3. LOAD addr=0x10, rsp_ready_i held 0 for 10 cycles.
//     - Required: rsp_valid_o=1 and rdata_o stable throughout.
//     - Required: req_ready_o=0 and a second req_valid_i is not accepted.
//  4. STORE addr=0x12 (misaligned), then STORE addr=DEPTH*4 with data=0x5A5A5A5A.
//     - Required: err_o=1 and rdata_o=0 for both.
//     - Required: a LOAD of 0x10 still returns the prior value.
//  5. STORE addr=0x20 data=0x1234, with rst_ni=0 during BUSY.
//     - Required: rsp_valid_o=0 and req_ready_o=1 after release.
//     - Required: a LOAD of 0x20 returns the old contents (write dropped).
//  6. Random 5000-cycle mix of LOAD/STORE with random aligned addresses and random rsp_ready_i.
//     - Required: a reference model matches every rdata_o and err_o.
//     - Required: zero fails.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering one LOAD/STORE request at a time over
// valid/ready request and response channels, after a fixed access latency.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned             IDX_W      = $clog2(DEPTH);
  localparam logic [DATA_WIDTH:0]     ADDR_LIMIT = (DATA_WIDTH + 1)'(DEPTH) << 2;
  localparam logic [3:0]              CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   addr_q, wdata_q;
  logic                    accept, access;
  logic                    op_we, op_err;
  logic [DATA_WIDTH-1:0]   op_addr, op_wdata;
  logic [IDX_W-1:0]        op_idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign req_ready_o = rst_ni && (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign accept      = req_valid_i && req_ready_o;

  // With LATENCY=1 the access happens on the accept edge itself, before the
  // capture registers hold the request, so IDLE uses the live inputs.
  assign op_we    = (state_q == IDLE) ? we_i    : we_q;
  assign op_addr  = (state_q == IDLE) ? addr_i  : addr_q;
  assign op_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
  assign op_err   = (op_addr[1:0] != 2'b00) || ({1'b0, op_addr} >= ADDR_LIMIT);
  assign op_idx   = op_addr[2 +: IDX_W];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = CNT_INIT;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d = RESP;
            access  = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (access) begin
        err_o   <= op_err;
        rdata_o <= (op_we || op_err) ? '0 : mem[op_idx];
      end
    end
  end

  // NOTE: the array has no reset branch; contents survive reset and the array
  // maps onto plain RAM. Gating with rst_ni drops a store caught by reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && access && op_we && !op_err) mem[op_idx] <= op_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 15) share one
// stimulus path; a word-array model predicts every response.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, we, rsp_ready;
  logic [31:0] addr, wdata;
  int          sel;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          last_acc = 0;
  int          acc_gap = 0;

  logic        rq_rdy [3];
  logic        rs_vld [3];
  logic        err_a  [3];
  logic [31:0] rdata_a[3];
  logic        dut_ready, dut_valid, dut_err;
  logic [31:0] dut_rdata;

  bit   [31:0] mm [3][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid && sel == 0), .req_ready_o(rq_rdy[0]),
    .we_i(we), .addr_i(addr), .wdata_i(wdata), .rsp_valid_o(rs_vld[0]),
    .rsp_ready_i(rsp_ready && sel == 0), .rdata_o(rdata_a[0]), .err_o(err_a[0]));

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid && sel == 1), .req_ready_o(rq_rdy[1]),
    .we_i(we), .addr_i(addr), .wdata_i(wdata), .rsp_valid_o(rs_vld[1]),
    .rsp_ready_i(rsp_ready && sel == 1), .rdata_o(rdata_a[1]), .err_o(err_a[1]));

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .LATENCY(15)) u_l15 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid && sel == 2), .req_ready_o(rq_rdy[2]),
    .we_i(we), .addr_i(addr), .wdata_i(wdata), .rsp_valid_o(rs_vld[2]),
    .rsp_ready_i(rsp_ready && sel == 2), .rdata_o(rdata_a[2]), .err_o(err_a[2]));

  always_comb begin
    dut_ready = rq_rdy[sel];
    dut_valid = rs_vld[sel];
    dut_err   = err_a[sel];
    dut_rdata = rdata_a[sel];
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (lat=%0d cyc=%0d): got=%h exp=%h", tag, lat_of(sel), cyc, got, exp);
    end
  endtask

  // Entered and left at a negedge. hold = cycles the response is backpressured.
  task automatic txn(input bit st, input logic [31:0] a, input logic [31:0] d, input int hold);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          waits;
    exp_err = (a[1:0] != 2'b00) || (a >= 32'h1000);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (st) mm[sel][a[11:2]] = d;
      else    exp_rd = mm[sel][a[11:2]];
    end
    req_valid = 1'b1; we = st; addr = a; wdata = d;
    check("req_ready_idle", 32'(dut_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_gap  = cyc - last_acc;
    last_acc = cyc;
    req_valid = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    waits = 0;
    while (!dut_valid && waits < 40) begin
      check("req_ready_busy", 32'(dut_ready), 32'd0);
      @(negedge clk);
      waits++;
    end
    check("rsp_latency", waits, lat_of(sel) - 1);
    if (!dut_valid) return;
    check("rdata", dut_rdata, exp_rd);
    check("err", 32'(dut_err), 32'(exp_err));
    check("req_ready_resp", 32'(dut_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      addr = $urandom; wdata = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(dut_valid), 32'd1);
      check("hold_rdata", dut_rdata, exp_rd);
      check("hold_ready", 32'(dut_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(dut_valid), 32'd0);
    check("post_hs_ready", 32'(dut_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; we = 1'b0; rsp_ready = 1'b0;
    addr = '0; wdata = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_ready", 32'(dut_ready), 32'd0);
      check("rst_valid", 32'(dut_valid), 32'd0);
      check("rst_rdata", dut_rdata, 32'd0);
      check("rst_err", 32'(dut_err), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Known contents for the low 16 words and the last word of every instance.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int w = 0; w < 16; w++) txn(1'b1, 32'(w * 4), $urandom, 0);
      txn(1'b1, 32'hFFC, 32'h600DF00D, 0);
      txn(1'b0, 32'hFFC, 32'h0, 0);
    end

    // Store/load round trip at LATENCY=2.
    sel = 0;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h10, 32'h0, 0);
    check("raw_model", mm[0][4], 32'hDEADBEEF);

    // Back-to-back loads: accept-to-accept spacing is LATENCY+1.
    for (int s = 1; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 5; i++) begin
        txn(1'b0, 32'($urandom_range(0, 15) * 4), 32'h0, 0);
        if (i > 0) check("throughput", acc_gap, lat_of(s) + 1);
      end
    end

    // Backpressure, then error accesses leave memory untouched.
    sel = 0;
    txn(1'b0, 32'h10, 32'h0, 10);
    txn(1'b1, 32'h12, 32'h5A5A5A5A, 0);
    txn(1'b1, 32'h1000, 32'h5A5A5A5A, 0);
    txn(1'b0, 32'h10, 32'h0, 0);
    txn(1'b0, 32'h1000, 32'h0, 0);

    // Reset while a store sits in BUSY: the write is dropped.
    sel = 2;
    txn(1'b1, 32'h20, 32'hCAFEF00D, 0);
    req_valid = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_ready", 32'(dut_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(dut_ready), 32'd0);
    check("midrst_valid", 32'(dut_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_valid", 32'(dut_valid), 32'd0);
    check("rel_ready", 32'(dut_ready), 32'd1);
    txn(1'b0, 32'h20, 32'h0, 0);

    // Random mix across all three latencies.
    begin
      int stop;
      stop = cyc + 5000;
      while (cyc < stop) begin
        int          r;
        logic [31:0] a;
        sel = $urandom_range(0, 2);
        r   = $urandom_range(0, 9);
        if (r < 8)       a = 32'($urandom_range(0, 15) * 4);
        else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 4000) * 4);
        else             a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        txn(1'($urandom), a, $urandom, $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
